// File: rtl/stream_mux_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : stream_mux_if
// Description : Bundle of the handshake and statistics signals of stream_mux.
//               Packet, metadata and user inputs come in; the merged stream
//               and the statistics counters go out.
//               slave  : the mux itself
//               master : the environment around the mux (sources, sink)
// Revision    : 1.0 - initial release
// ============================================================================
interface stream_mux_if #(
  parameter int DATA_W  = 512,
  parameter int EMPTY_W = 6,
  parameter int META_W  = 256
);
  // Packet source
  logic [DATA_W-1:0]  in_pkt_data;
  logic               in_pkt_valid;
  logic               in_pkt_sop;
  logic               in_pkt_eop;
  logic [EMPTY_W-1:0] in_pkt_empty;
  logic               in_pkt_ready;
  // Metadata source, one word per packet
  logic [META_W-1:0]  in_meta_data;
  logic               in_meta_valid;
  logic               in_meta_ready;
  // User source
  logic [DATA_W-1:0]  in_usr_data;
  logic               in_usr_valid;
  logic               in_usr_sop;
  logic               in_usr_eop;
  logic [EMPTY_W-1:0] in_usr_empty;
  logic               in_usr_ready;
  // Merged output
  logic [DATA_W-1:0]  out_data;
  logic               out_valid;
  logic               out_sop;
  logic               out_eop;
  logic [EMPTY_W-1:0] out_empty;
  logic               out_ready;
  logic               out_almost_full;
  // Statistics
  logic [31:0]        stat_pkt_cnt;
  logic [31:0]        stat_usr_cnt;
  logic [31:0]        stat_err_cnt;

  modport slave (
    input  in_pkt_data, in_pkt_valid, in_pkt_sop, in_pkt_eop, in_pkt_empty,
    output in_pkt_ready,
    input  in_meta_data, in_meta_valid,
    output in_meta_ready,
    input  in_usr_data, in_usr_valid, in_usr_sop, in_usr_eop, in_usr_empty,
    output in_usr_ready,
    output out_data, out_valid, out_sop, out_eop, out_empty,
    input  out_ready, out_almost_full,
    output stat_pkt_cnt, stat_usr_cnt, stat_err_cnt
  );

  modport master (
    output in_pkt_data, in_pkt_valid, in_pkt_sop, in_pkt_eop, in_pkt_empty,
    input  in_pkt_ready,
    output in_meta_data, in_meta_valid,
    input  in_meta_ready,
    output in_usr_data, in_usr_valid, in_usr_sop, in_usr_eop, in_usr_empty,
    input  in_usr_ready,
    input  out_data, out_valid, out_sop, out_eop, out_empty,
    output out_ready, out_almost_full,
    input  stat_pkt_cnt, stat_usr_cnt, stat_err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/stream_mux.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : stream_mux
// Description : Merges a packet stream (with one metadata word per packet)
//               and a user stream into one output stream. Every output frame
//               is a header flit (tag + metadata) followed by the payload of
//               one input packet. Round-robin arbitration between sources,
//               single registered output stage, saturating statistics.
// Ports       : clk, rst (async, active-high)
//               bus (stream_mux_if.slave) - all stream and statistics signals
// Revision    : 1.0 - initial release
// ============================================================================
module stream_mux #(
  parameter int DATA_W  = 512,
  parameter int EMPTY_W = 6,
  parameter int META_W  = 256   // must not exceed DATA_W-2
) (
  input  logic          clk,
  input  logic          rst,
  stream_mux_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PKT_BODY = 2'd1,
    S_USR_BODY = 2'd2
  } state_t;

  localparam logic [1:0] c_TAG_PKT = 2'b01;
  localparam logic [1:0] c_TAG_USR = 2'b10;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_last_pkt;   // 1: last grant went to the packet source
  logic               r_first;      // next body flit is the frame's own sop flit

  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_data;
  logic               r_out_sop;
  logic               r_out_eop;
  logic [EMPTY_W-1:0] r_out_empty;

  logic [31:0]        r_pkt_cnt;
  logic [31:0]        r_usr_cnt;
  logic [31:0]        r_err_cnt;

  logic               w_ld;
  logic               w_pkt_elig, w_usr_elig;
  logic               w_grant_pkt, w_grant_usr;
  logic               w_pkt_acc, w_usr_acc;
  logic               w_pkt_drop, w_usr_drop;
  logic               w_pkt_ready, w_usr_ready, w_meta_ready;
  logic [1:0]         w_err_inc;
  logic [DATA_W-1:0]  w_hdr_pkt, w_hdr_usr;

  assign w_ld       = !r_out_valid || bus.out_ready;
  assign w_pkt_elig = bus.in_pkt_valid && bus.in_pkt_sop && bus.in_meta_valid
                      && !bus.out_almost_full;
  assign w_usr_elig = bus.in_usr_valid && bus.in_usr_sop && !bus.out_almost_full;

  always_comb begin
    w_hdr_pkt                   = '0;
    w_hdr_pkt[DATA_W-1 -: 2]    = c_TAG_PKT;
    w_hdr_pkt[META_W-1:0]       = bus.in_meta_data;
    w_hdr_usr                   = '0;
    w_hdr_usr[DATA_W-1 -: 2]    = c_TAG_USR;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_pkt  = 1'b0;
    w_grant_usr  = 1'b0;
    w_pkt_acc    = 1'b0;
    w_usr_acc    = 1'b0;
    w_pkt_drop   = 1'b0;
    w_usr_drop   = 1'b0;
    w_pkt_ready  = 1'b0;
    w_usr_ready  = 1'b0;
    w_meta_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A non-sop flit at the head of a source is a framing error: drain it
        // without producing output, independent of the output stage.
        w_pkt_drop  = bus.in_pkt_valid && !bus.in_pkt_sop;
        w_usr_drop  = bus.in_usr_valid && !bus.in_usr_sop;
        w_pkt_ready = w_pkt_drop;
        w_usr_ready = w_usr_drop;
        if (w_ld) begin
          if (w_pkt_elig && (!w_usr_elig || !r_last_pkt)) begin
            w_grant_pkt = 1'b1;
            w_state_nxt = S_PKT_BODY;
          end else if (w_usr_elig) begin
            w_grant_usr = 1'b1;
            w_state_nxt = S_USR_BODY;
          end
        end
        // The sop flit itself stays queued; only the metadata is popped.
        w_meta_ready = w_grant_pkt;
      end
      S_PKT_BODY: begin
        w_pkt_ready = w_ld;
        w_pkt_acc   = w_ld && bus.in_pkt_valid;
        if (w_pkt_acc && bus.in_pkt_eop) w_state_nxt = S_IDLE;
      end
      S_USR_BODY: begin
        w_usr_ready = w_ld;
        w_usr_acc   = w_ld && bus.in_usr_valid;
        if (w_usr_acc && bus.in_usr_eop) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A sop inside a body is an error unless it is the frame's own first flit.
  assign w_err_inc = {1'b0, w_pkt_drop} + {1'b0, w_usr_drop}
                   + {1'b0, w_pkt_acc && bus.in_pkt_sop && !r_first}
                   + {1'b0, w_usr_acc && bus.in_usr_sop && !r_first};

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {31'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_last_pkt  <= 1'b0;
      r_first     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_out_empty <= '0;
      r_pkt_cnt   <= '0;
      r_usr_cnt   <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_pkt) r_last_pkt <= 1'b1;
      else if (w_grant_usr) r_last_pkt <= 1'b0;
      if (w_grant_pkt || w_grant_usr) r_first <= 1'b1;
      else if (w_pkt_acc || w_usr_acc) r_first <= 1'b0;

      if (w_ld) begin
        r_out_valid <= w_grant_pkt || w_grant_usr || w_pkt_acc || w_usr_acc;
        if (w_grant_pkt || w_grant_usr) begin
          r_out_data  <= w_grant_pkt ? w_hdr_pkt : w_hdr_usr;
          r_out_sop   <= 1'b1;
          r_out_eop   <= 1'b0;
          r_out_empty <= '0;
        end else if (w_pkt_acc) begin
          r_out_data  <= bus.in_pkt_data;
          r_out_sop   <= 1'b0;
          r_out_eop   <= bus.in_pkt_eop;
          r_out_empty <= bus.in_pkt_empty;
        end else if (w_usr_acc) begin
          r_out_data  <= bus.in_usr_data;
          r_out_sop   <= 1'b0;
          r_out_eop   <= bus.in_usr_eop;
          r_out_empty <= bus.in_usr_empty;
        end
      end

      r_pkt_cnt <= sat_add(r_pkt_cnt, {1'b0, w_pkt_acc && bus.in_pkt_eop});
      r_usr_cnt <= sat_add(r_usr_cnt, {1'b0, w_usr_acc && bus.in_usr_eop});
      r_err_cnt <= sat_add(r_err_cnt, w_err_inc);
    end
  end

  // Readies are forced low while reset is held.
  assign bus.in_pkt_ready  = w_pkt_ready  && !rst;
  assign bus.in_usr_ready  = w_usr_ready  && !rst;
  assign bus.in_meta_ready = w_meta_ready && !rst;

  assign bus.out_valid    = r_out_valid;
  assign bus.out_data     = r_out_data;
  assign bus.out_sop      = r_out_sop;
  assign bus.out_eop      = r_out_eop;
  assign bus.out_empty    = r_out_empty;
  assign bus.stat_pkt_cnt = r_pkt_cnt;
  assign bus.stat_usr_cnt = r_usr_cnt;
  assign bus.stat_err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: doc/stream_mux.md
STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 Parameters: DATA_W = 512, flit width. EMPTY_W = 6, empty field width. META_W = 256, metadata width (SHALL be <= DATA_W-2).
REQ-002 Clock: clk, input, 1 bit, rising-edge clock for all state.
REQ-003 Reset: rst, input, 1 bit; one clock; reset is asynchronous and active-high.
REQ-004 Packet input: in_pkt_data[DATA_W], in_pkt_valid, in_pkt_sop, in_pkt_eop, in_pkt_empty[EMPTY_W] are inputs; in_pkt_ready is an output.
REQ-005 Metadata input: in_meta_data[META_W] and in_meta_valid are inputs, one word per packet; in_meta_ready is an output.
REQ-006 User input: in_usr_data[DATA_W], in_usr_valid, in_usr_sop, in_usr_eop, in_usr_empty[EMPTY_W] are inputs; in_usr_ready is an output.
REQ-007 Merged output: out_data[DATA_W], out_valid, out_sop, out_eop, out_empty[EMPTY_W] are outputs; out_ready and out_almost_full are inputs.
REQ-008 Statistics outputs, 32 bits each: stat_pkt_cnt (packet frames), stat_usr_cnt (user frames), stat_err_cnt (framing errors).

Function
REQ-009 The output frame format SHALL be one header flit followed by the payload flits of exactly one input packet.
REQ-010 Header flit contents:
- out_sop=1, out_eop=0, out_empty=0.
- out_data[DATA_W-1:DATA_W-2] = tag: 2'b01 for packet, 2'b10 for user.
- Packet header: out_data[META_W-1:0] = metadata word; user header: those bits 0.
- All other bits 0.
REQ-011 Payload flits SHALL carry input data, eop and empty unchanged, with out_sop=0.
REQ-012 Output register:
- Single registered stage; load enable ld = !out_valid || out_ready.
- out_valid and out_* SHALL hold stable while out_valid && !out_ready.
REQ-013 States: IDLE, PKT_BODY, USR_BODY.
REQ-014 Eligibility in IDLE, both requiring out_almost_full=0:
- Packet: in_pkt_valid && in_pkt_sop && in_meta_valid.
- User: in_usr_valid && in_usr_sop.
REQ-015 Arbitration:
- Round-robin on last_grant; when both sources are eligible, grant the source not granted last.
- last_grant resets to USER, so packet wins the first tie.
REQ-016 Packet grant in IDLE with ld=1, same cycle:
- Load packet header; in_meta_ready=1 (meta popped).
- Set last_grant=PKT; next state PKT_BODY.
- The sop flit is not consumed by the grant.
REQ-017 User grant in IDLE with ld=1:
- Load user header; set last_grant=USER; next state USR_BODY.
REQ-018 Body states: in_pkt_ready (PKT_BODY) or in_usr_ready (USR_BODY) = ld, combinational from out_ready; every accepted flit is loaded into the output register.
REQ-019 When a flit with eop=1 is accepted in a body state, next state SHALL be IDLE and the matching stat counter increments.
REQ-020 Latency: input flit accepted at cycle N -> out_valid with that flit at N+1; header visible at grant cycle +1.
REQ-021 Throughput:
- Back-to-back frames SHALL have no idle cycle between one frame's eop and the next header.
- Header overhead is 1 cycle per frame.
REQ-022 out_almost_full=1 blocks only new grants; a frame in progress continues to eop.
REQ-023 Framing error, non-sop flit at head in IDLE:
- Flit with valid=1, sop=0 is drained (ready=1, flit discarded).
- stat_err_cnt increments; no output is produced.
REQ-024 Framing error, sop=1 inside a body state: flit forwarded with out_sop=0 and stat_err_cnt increments.
REQ-025 Metadata available without a packet sop SHALL wait; in_meta_ready=0 except at packet grant.
REQ-026 Counters SHALL saturate at 32'hFFFF_FFFF.
REQ-027 All ready outputs SHALL be 0 while rst=1.

Reset
REQ-028 On rst assertion, asynchronously:
- state=IDLE, last_grant=USER.
- out_valid=0, out_sop=0, out_eop=0, out_data=0, out_empty=0.
- All stat counters = 0.
REQ-029 Reset mid-frame SHALL abandon the partial frame; after release, the first grant requires a fresh sop.

Verification
REQ-030 Single packet: meta=0xA5 and a 3-flit packet with empty=5 on last, out_ready=1 -> 4 output flits: header tag 01 with data[7:0]=0xA5, then 3 payload flits; last has eop=1, empty=5; stat_pkt_cnt=1.
REQ-031 Tie: packet and user sop asserted together from reset -> packet frame first, then user frame (tag 10), with no idle cycle between them.
REQ-032 Backpressure: out_ready toggles 1/0 every cycle during a 4-flit user packet -> output held stable on stall cycles; all 5 flits delivered in order; none duplicated.
REQ-033 almost_full: out_almost_full=1 in IDLE with both sources valid -> out_valid stays 0; asserting it mid-frame -> frame still completes through eop.
REQ-034 Errors: usr flit sop=0 in IDLE -> dropped, stat_err_cnt=1; pkt flit sop=1 mid-body -> forwarded with out_sop=0, stat_err_cnt=2.
REQ-035 Reset at 2nd payload flit -> out_valid=0 within the same cycle; counters 0; next valid frame output correctly.
